// File: rtl/rfphoenix_mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: request/response payloads, tid layout and FSM states.
// The arbiter's optional I$ priority mode is selected with RFP_ARB_ICPRIO_EN.
package rfphoenix_mem_arbiter_pkg;

    localparam int NTHREADS   = 4;
    parameter int  ARB_MAXREQ = 8;

    typedef logic [2:0] ReqIdx;
    typedef logic [7:0] Tid;

    typedef struct packed {
        Tid          tid;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } MemoryRequest;

    typedef struct packed {
        Tid          tid;
        logic        cmt;
        logic [31:0] dat;
    } MemoryResponse;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // tid = {sequence, requester index}
    function automatic Tid mk_tid(input logic [4:0] seq, input ReqIdx idx);
        return {seq, idx};
    endfunction

endpackage

// File: rtl/rfphoenix_rr_pick.sv
// Combinational round-robin picker: first eligible index strictly after `last`, wrapping to 0.
module rfphoenix_rr_pick
    import rfphoenix_mem_arbiter_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0] elig,
    input  ReqIdx        last,
    output logic [N-1:0] gnt,
    output ReqIdx        idx,
    output logic         any
);

    ReqIdx idx_hi;
    ReqIdx idx_lo;
    logic  found_hi;

    // Descending scan leaves the lowest eligible index overall and the lowest one above `last`.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        any      = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (elig[j]) begin
                idx_lo = ReqIdx'(j);
                any    = 1'b1;
                if (ReqIdx'(j) > last) begin
                    idx_hi   = ReqIdx'(j);
                    found_hi = 1'b1;
                end
            end
        end
        idx = found_hi ? idx_hi : idx_lo;
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/rfphoenix_mem_arbiter.sv
// Arbitrates requesters onto the single memory-unit port, stamps tids and routes responses back.
// Define RFP_ARB_ICPRIO_EN to give requester 0 (I$ miss) absolute priority over the thread LSUs.
module rfphoenix_mem_arbiter
    import rfphoenix_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = NTHREADS + 1,
    parameter int MAXOUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic         [NREQ-1:0]  req_v_i,
    input  MemoryRequest [NREQ-1:0]  req_i,
    output logic         [NREQ-1:0]  req_rdy_o,
    output logic                     mreq_v_o,
    output MemoryRequest             mreq_o,
    input  logic                     mreq_rdy_i,
    input  logic                     mresp_v_i,
    input  MemoryResponse            mresp_i,
    output logic         [NREQ-1:0]  resp_v_o,
    output MemoryResponse            resp_o,
    output logic                     busy_o
);

    arb_state_t            state, state_nx;
    ReqIdx                 last;
    logic [4:0]            seq;
    logic [NREQ-1:0][2:0]  outcnt, outcnt_nx;
    logic                  err_underflow;
    logic                  uflow;

    logic [NREQ-1:0] elig, rr_elig, rr_gnt, gnt;
    logic [NREQ-1:0] inc_v, dec_v;
    ReqIdx           rr_idx, win_idx, rsp_idx;
    logic            rr_any, win_any, grant, upd_last, rsp_hit;
    MemoryRequest    grant_req;

    always_comb begin
        elig = '0;
        for (int n = 0; n < NREQ; n++) begin
            elig[n] = req_v_i[n] && (outcnt[n] < 3'(MAXOUT));
        end
    end

`ifdef RFP_ARB_ICPRIO_EN
    assign rr_elig = elig & ~NREQ'(1);
`else
    assign rr_elig = elig;
`endif

    rfphoenix_rr_pick #(.N(NREQ)) u_rr_pick (
        .elig (rr_elig),
        .last (last),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    always_comb begin
        gnt      = rr_gnt;
        win_idx  = rr_idx;
        win_any  = rr_any;
        upd_last = 1'b1;
`ifdef RFP_ARB_ICPRIO_EN
        // I$ wins outright and leaves the thread rotation where it was.
        if (elig[0]) begin
            gnt      = NREQ'(1);
            win_idx  = '0;
            win_any  = 1'b1;
            upd_last = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ARB_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        req_rdy_o = '0;
        case (state)
            ARB_IDLE: begin
                if (win_any) begin
                    grant     = 1'b1;
                    req_rdy_o = gnt;
                    state_nx  = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (mreq_rdy_i) state_nx = ARB_IDLE;
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant_req = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (gnt[n]) grant_req = req_i[n];
        end
        grant_req.tid = mk_tid(seq, win_idx);
    end

    // Request output register: loaded on grant, held until the memory unit takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mreq_v_o <= 1'b0;
            mreq_o   <= '0;
            seq      <= '0;
            last     <= ReqIdx'(NREQ - 1);
        end else if (grant) begin
            mreq_v_o <= 1'b1;
            mreq_o   <= grant_req;
            seq      <= seq + 5'd1;
            if (upd_last) last <= win_idx;
        end else if (state == ARB_HOLD && mreq_rdy_i) begin
            mreq_v_o <= 1'b0;
        end
    end

    assign rsp_idx = mresp_i.tid[2:0];
    assign rsp_hit = mresp_v_i && (int'(rsp_idx) < NREQ);

    // Response output register: one-cycle strobe, out-of-range indices dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_v_o <= '0;
            resp_o   <= '0;
        end else begin
            resp_v_o <= '0;
            if (mresp_v_i) begin
                resp_o <= mresp_i;
                if (rsp_hit) resp_v_o <= NREQ'(1) << rsp_idx;
            end
        end
    end

    assign inc_v = grant ? gnt : '0;
    assign dec_v = (rsp_hit && mresp_i.cmt) ? (NREQ'(1) << rsp_idx) : '0;

    // A grant and a final beat on the same requester cancel; a decrement at zero saturates.
    always_comb begin
        outcnt_nx = outcnt;
        uflow     = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            if (inc_v[n] && !dec_v[n]) begin
                outcnt_nx[n] = outcnt[n] + 3'd1;
            end else if (dec_v[n] && !inc_v[n]) begin
                if (outcnt[n] == 3'd0) uflow = 1'b1;
                else                   outcnt_nx[n] = outcnt[n] - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outcnt        <= '0;
            err_underflow <= 1'b0;
        end else begin
            outcnt        <= outcnt_nx;
            err_underflow <= err_underflow | uflow;
        end
    end

    logic unused_err;
    assign unused_err = err_underflow;

    assign busy_o = mreq_v_o | (|outcnt);

endmodule

// File: tb/tb_rfphoenix_mem_arbiter.sv
// Self-checking bench for rfphoenix_mem_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_rfphoenix_mem_arbiter;
    import rfphoenix_mem_arbiter_pkg::*;

    localparam int NREQ   = 5;
    localparam int MAXOUT = 4;

    logic                    clk = 1'b0;
    logic                    rst_ni = 1'b0;
    logic [NREQ-1:0]         req_v_i;
    MemoryRequest [NREQ-1:0] req_i;
    logic [NREQ-1:0]         req_rdy_o;
    logic                    mreq_v_o;
    MemoryRequest            mreq_o;
    logic                    mreq_rdy_i;
    logic                    mresp_v_i;
    MemoryResponse           mresp_i;
    logic [NREQ-1:0]         resp_v_o;
    MemoryResponse           resp_o;
    logic                    busy_o;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int              m_cnt [NREQ];
    logic [4:0]      m_seq;
    int              m_last;
    logic            m_mreq_v;
    MemoryRequest    m_mreq;
    logic [NREQ-1:0] m_resp_v;
    MemoryResponse   m_resp;
    Tid              pend [$];

    always #5 clk = ~clk;

    rfphoenix_mem_arbiter #(.NREQ(NREQ), .MAXOUT(MAXOUT)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .req_v_i    (req_v_i),
        .req_i      (req_i),
        .req_rdy_o  (req_rdy_o),
        .mreq_v_o   (mreq_v_o),
        .mreq_o     (mreq_o),
        .mreq_rdy_i (mreq_rdy_i),
        .mresp_v_i  (mresp_v_i),
        .mresp_i    (mresp_i),
        .resp_v_o   (resp_v_o),
        .resp_o     (resp_o),
        .busy_o     (busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_v_i    = '0;
        req_i      = '0;
        mreq_rdy_i = 1'b1;
        mresp_v_i  = 1'b0;
        mresp_i    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    function automatic MemoryRequest rnd_req();
        MemoryRequest r;
        r.tid = 8'($urandom);
        r.we  = 1'($urandom);
        r.sel = 4'($urandom);
        r.adr = $urandom;
        r.dat = $urandom;
        return r;
    endfunction

    // Winner under the arbitration rules, -1 when nothing is granted this cycle.
    function automatic int model_pick(input logic [NREQ-1:0] rv);
        int n;
        if (m_mreq_v) return -1;
`ifdef RFP_ARB_ICPRIO_EN
        if (rv[0] && m_cnt[0] < MAXOUT) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            n = (m_last + k) % NREQ;
`ifdef RFP_ARB_ICPRIO_EN
            if (n == 0) continue;
`endif
            if (rv[n] && m_cnt[n] < MAXOUT) return n;
        end
        return -1;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        total++;
        if ({mreq_v_o, mreq_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL reset_mreq got v=%0b req=%h busy=%0b exp all 0", mreq_v_o, mreq_o, busy_o);
        end
        total++;
        if ({resp_v_o, resp_o, req_rdy_o} !== '0) begin
            bad++;
            $display("FAIL reset_resp got v=%b resp=%h rdy=%b exp all 0", resp_v_o, resp_o, req_rdy_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_single();
        MemoryRequest r;
        do_reset();
        r = rnd_req();
        req_i[2] = r;
        req_v_i  = 5'b00100;
        #1;
        total++;
        if (req_rdy_o !== 5'b00100) begin
            bad++;
            $display("FAIL single_rdy got=%b exp=00100", req_rdy_o);
        end
        tick();
        req_v_i = '0;
        total++;
        if (mreq_v_o !== 1'b1 || mreq_o.tid !== 8'h02) begin
            bad++;
            $display("FAIL single_tid got v=%0b tid=%h exp v=1 tid=02", mreq_v_o, mreq_o.tid);
        end
        total++;
        if ({mreq_o.we, mreq_o.sel, mreq_o.adr, mreq_o.dat} !== {r.we, r.sel, r.adr, r.dat}) begin
            bad++;
            $display("FAIL single_payload got=%h exp=%h", mreq_o, r);
        end
        tick();
        total++;
        if (mreq_v_o !== 1'b0) begin
            bad++;
            $display("FAIL single_accept got v=%0b exp 0", mreq_v_o);
        end
        req_i[2] = rnd_req();
        req_v_i  = 5'b00100;
        tick();
        req_v_i = '0;
        total++;
        if (mreq_o.tid !== 8'h0A) begin
            bad++;
            $display("FAIL single_seq got tid=%h exp=0a", mreq_o.tid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_order [6];
        logic [NREQ-1:0] exp;
`ifdef RFP_ARB_ICPRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 2};
`else
        exp_order = '{0, 1, 2, 3, 4, 0};
`endif
        do_reset();
        for (int n = 0; n < NREQ; n++) req_i[n] = rnd_req();
        req_v_i = '1;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp = (c % 2 == 0) ? (NREQ'(1) << exp_order[c / 2]) : '0;
            total++;
            if (req_rdy_o !== exp) begin
                bad++;
                $display("FAIL rr_rdy cyc=%0d got=%b exp=%b", c, req_rdy_o, exp);
            end
            tick();
            if (c % 2 == 0) begin
                total++;
                if (mreq_o.tid !== {5'(c / 2), 3'(exp_order[c / 2])}) begin
                    bad++;
                    $display("FAIL rr_tid cyc=%0d got=%h exp=%h", c, mreq_o.tid, {5'(c / 2), 3'(exp_order[c / 2])});
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        MemoryRequest saved;
        do_reset();
        req_i[1]   = rnd_req();
        req_v_i    = 5'b00010;
        mreq_rdy_i = 1'b0;
        tick();
        saved    = mreq_o;
        req_v_i  = 5'b01000;
        req_i[1] = rnd_req();
        req_i[3] = rnd_req();
        for (int c = 0; c < 6; c++) begin
            if (c == 5) mreq_rdy_i = 1'b1;
            #1;
            total++;
            if (req_rdy_o !== '0 || mreq_v_o !== 1'b1 || mreq_o !== saved) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%0b req=%h exp rdy=0 v=1 req=%h", c, req_rdy_o, mreq_v_o, mreq_o, saved);
            end
            tick();
            req_i[1] = rnd_req();
        end
        total++;
        if (mreq_v_o !== 1'b0 || req_rdy_o !== 5'b01000) begin
            bad++;
            $display("FAIL bp_release got v=%0b rdy=%b exp v=0 rdy=01000", mreq_v_o, req_rdy_o);
        end
        tick();
        total++;
        if (mreq_o.tid !== 8'h0B) begin
            bad++;
            $display("FAIL bp_next_tid got=%h exp=0b", mreq_o.tid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_outstanding_limit();
        int ng;
        ng = 0;
        do_reset();
        req_i[1] = rnd_req();
        req_v_i  = 5'b00010;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_rdy_o[1]) ng++;
            tick();
        end
        total++;
        if (ng !== MAXOUT) begin
            bad++;
            $display("FAIL limit_grants got=%0d exp=%0d", ng, MAXOUT);
        end
        mresp_v_i   = 1'b1;
        mresp_i.tid = 8'h01;
        mresp_i.cmt = 1'b1;
        mresp_i.dat = $urandom;
        #1;
        total++;
        if (req_rdy_o !== '0) begin
            bad++;
            $display("FAIL limit_full got rdy=%b exp=00000", req_rdy_o);
        end
        tick();
        mresp_v_i = 1'b0;
        total++;
        if (resp_v_o !== 5'b00010) begin
            bad++;
            $display("FAIL limit_resp got=%b exp=00010", resp_v_o);
        end
        #1;
        total++;
        if (req_rdy_o !== 5'b00010) begin
            bad++;
            $display("FAIL limit_regrant got rdy=%b exp=00010", req_rdy_o);
        end
        tick();
        total++;
        if (mreq_o.tid !== 8'h21) begin
            bad++;
            $display("FAIL limit_tid got=%h exp=21", mreq_o.tid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_resp_routing();
        logic [31:0] d;
        do_reset();
        req_i[3] = rnd_req();
        req_v_i  = 5'b01000;
        tick();
        req_v_i = '0;
        tick();
        d = $urandom;
        mresp_v_i = 1'b1;
        mresp_i   = '{tid: 8'h1B, cmt: 1'b0, dat: d};
        tick();
        total++;
        if (resp_v_o !== 5'b01000 || resp_o.dat !== d || resp_o.cmt !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL route_beat got v=%b dat=%h cmt=%0b busy=%0b exp v=01000 dat=%h cmt=0 busy=1", resp_v_o, resp_o.dat, resp_o.cmt, busy_o, d);
        end
        mresp_i.cmt = 1'b1;
        tick();
        total++;
        if (resp_v_o !== 5'b01000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL route_final got v=%b busy=%0b exp v=01000 busy=0", resp_v_o, busy_o);
        end
        mresp_i.tid = 8'h07;
        tick();
        total++;
        if (resp_v_o !== '0 || busy_o !== 1'b0 || dut.err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL route_drop got v=%b busy=%0b uflow=%0b exp 0 0 0", resp_v_o, busy_o, dut.err_underflow);
        end
        mresp_v_i = 1'b0;
        tick();
        total++;
        if (resp_v_o !== '0) begin
            bad++;
            $display("FAIL route_single got v=%b exp=00000", resp_v_o);
        end
    endtask

    task automatic test_random();
        int w, pi, idx;
        logic [NREQ-1:0] exp_rdy;
        logic exp_busy;
        do_reset();
        for (int n = 0; n < NREQ; n++) m_cnt[n] = 0;
        m_seq = '0; m_last = NREQ - 1; m_mreq_v = 1'b0; m_mreq = '0;
        m_resp_v = '0; m_resp = '0;
        pend.delete();
        for (int c = 0; c < 400; c++) begin
            req_v_i = NREQ'($urandom) & NREQ'($urandom);
            for (int n = 0; n < NREQ; n++) req_i[n] = rnd_req();
            mreq_rdy_i = ($urandom_range(0, 3) != 0);
            mresp_v_i = 1'b0;
            mresp_i   = '0;
            pi = -1;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                pi = $urandom_range(0, pend.size() - 1);
                mresp_v_i = 1'b1;
                mresp_i   = '{tid: pend[pi], cmt: 1'($urandom), dat: $urandom};
            end else if ($urandom_range(0, 15) == 0) begin
                mresp_v_i = 1'b1;
                mresp_i   = '{tid: {5'($urandom), 3'($urandom_range(NREQ, 7))}, cmt: 1'($urandom), dat: $urandom};
            end
            #1;
            w = model_pick(req_v_i);
            exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
            total++;
            if (req_rdy_o !== exp_rdy) begin
                bad++;
                $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", c, req_rdy_o, exp_rdy);
            end
            tick();
            if (pi >= 0 && mresp_i.cmt) pend.delete(pi);
            if (w >= 0) begin
                m_cnt[w]++;
                m_mreq     = req_i[w];
                m_mreq.tid = {m_seq, 3'(w)};
                pend.push_back(m_mreq.tid);
                m_seq++;
                m_mreq_v = 1'b1;
`ifdef RFP_ARB_ICPRIO_EN
                if (w != 0) m_last = w;
`else
                m_last = w;
`endif
            end else if (m_mreq_v && mreq_rdy_i) begin
                m_mreq_v = 1'b0;
            end
            m_resp_v = '0;
            if (mresp_v_i) begin
                idx    = int'(mresp_i.tid[2:0]);
                m_resp = mresp_i;
                if (idx < NREQ) begin
                    m_resp_v = NREQ'(1) << idx;
                    if (mresp_i.cmt && m_cnt[idx] > 0) m_cnt[idx]--;
                end
            end
            exp_busy = m_mreq_v;
            for (int n = 0; n < NREQ; n++) if (m_cnt[n] > 0) exp_busy = 1'b1;
            total++;
            if (mreq_v_o !== m_mreq_v || mreq_o !== m_mreq) begin
                bad++;
                $display("FAIL rnd_mreq cyc=%0d got v=%0b req=%h exp v=%0b req=%h", c, mreq_v_o, mreq_o, m_mreq_v, m_mreq);
            end
            total++;
            if (resp_v_o !== m_resp_v || resp_o !== m_resp || busy_o !== exp_busy) begin
                bad++;
                $display("FAIL rnd_resp cyc=%0d got v=%b resp=%h busy=%0b exp v=%b resp=%h busy=%0b", c, resp_v_o, resp_o, busy_o, m_resp_v, m_resp, exp_busy);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (dut.err_underflow !== 1'b0) begin
            bad++;
            $display("FAIL rnd_uflow got=%0b exp=0", dut.err_underflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_i[1] = rnd_req();
        req_v_i  = 5'b00010;
        for (int c = 0; c < 4; c++) tick();
        mreq_rdy_i = 1'b0;
        tick();
        req_v_i = '0;
        total++;
        if (mreq_v_o !== 1'b1 || busy_o !== 1'b1 || mreq_o.tid !== 8'h11) begin
            bad++;
            $display("FAIL arst_pre got v=%0b busy=%0b tid=%h exp v=1 busy=1 tid=11", mreq_v_o, busy_o, mreq_o.tid);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({mreq_v_o, mreq_o, resp_v_o, resp_o, busy_o} !== '0) begin
            bad++;
            $display("FAIL arst_clear got v=%0b req=%h rv=%b resp=%h busy=%0b exp all 0", mreq_v_o, mreq_o, resp_v_o, resp_o, busy_o);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        mreq_rdy_i = 1'b1;
        mresp_v_i  = 1'b1;
        mresp_i    = '{tid: 8'h11, cmt: 1'b1, dat: $urandom};
        tick();
        mresp_v_i = 1'b0;
        total++;
        if (resp_v_o !== 5'b00010 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL arst_stray got v=%b busy=%0b exp v=00010 busy=0", resp_v_o, busy_o);
        end
        total++;
        if (dut.err_underflow !== 1'b1) begin
            bad++;
            $display("FAIL arst_uflow got=%0b exp=1", dut.err_underflow);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_outstanding_limit();
        test_resp_routing();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rfphoenix_mem_arbiter.md
# rfphoenix_mem_arbiter

Shares the single memory-unit request port between the I$ miss engine and the per-thread load/store units. Stamps each request with a transaction id, holds it in an output register until the memory unit accepts it, limits outstanding transactions per requester, and routes `MemoryResponse` beats back to the originating requester by tid. Sits between the execute/I$ stage and the memory/TLB pipeline.

## Interface
Parameters:
- `NREQ`, default `NTHREADS+1`. Number of requesters. Index 0 is I$ miss; indices 1..NTHREADS are thread LSUs. Maximum 8.
- `MAXOUT`, default 4. Maximum outstanding transactions per requester, range 1..7.

Ports:
- `clk_i`  in  1  Clock.
- `rst_ni`  in  1  Reset; asynchronous, active-low.
- `req_v_i`  in  NREQ  Request valid, one bit per requester.
- `req_i`  in  NREQ×MemoryRequest  Request payloads; `tid` field ignored.
- `req_rdy_o`  out  NREQ  One-hot accept. The request is taken on the cycle `req_v_i[n] & req_rdy_o[n]`.
- `mreq_v_o`  out  1  Valid toward the memory unit.
- `mreq_o`  out  MemoryRequest  Registered request with `tid` stamped.
- `mreq_rdy_i`  in  1  Memory unit accepts `mreq_o`.
- `mresp_v_i`  in  1  Response valid from the memory unit.
- `mresp_i`  in  MemoryResponse  Response payload.
- `resp_v_o`  out  NREQ  One-hot, registered response valid.
- `resp_o`  out  MemoryResponse  Registered response, broadcast to all requesters.
- `busy_o`  out  1  High when any transaction is outstanding or `mreq_v_o` is high.

## Operation
Tid format:
- `tid[2:0]` = requester index.
- `tid[7:3]` = 5-bit per-arbiter sequence counter. It increments on every grant and wraps 31→0.

Eligibility:
- Requester n is eligible when `req_v_i[n]` is high and `outcnt[n] < MAXOUT`.

FSM has two states, IDLE and HOLD.
- IDLE:
  - If any requester is eligible, pick one by round-robin starting at `last+1` (mod NREQ).
  - Assert `req_rdy_o[n]` combinationally for the winner.
  - Load `mreq_o` with the payload and stamped tid, set `mreq_v_o`, update `last` to n.
  - `outcnt[n]` increments.
  - Next state is HOLD.
- HOLD:
  - `req_rdy_o` is all zero.
  - On `mreq_rdy_i`, clear `mreq_v_o` and go to IDLE.
  - No back-to-back grant occurs in the acceptance cycle, so sustained throughput is one request per 2 cycles.

Response routing:
- On `mresp_v_i`, register `resp_o <= mresp_i` and set `resp_v_o` one-hot at index `mresp_i.tid[2:0]`.
- Decrement `outcnt` for that index only when `mresp_i.cmt` is high (final beat). Non-final beats do not decrement.
- A tid index ≥ NREQ is dropped: `resp_v_o` stays 0 and no counter changes.

Counters:
- `outcnt` width is 3 bits.
- A grant and a final response for the same requester in the same cycle leave the count unchanged.
- Decrement at 0 saturates at 0 and sets the sticky sim-only flag `err_underflow`.

Reset mid-operation:
- All state clears immediately.
- In-flight responses arriving after reset are routed but do not underflow the counters (saturation applies).

## Timing
- Reset values: `mreq_v_o=0`, `mreq_o=0`, `resp_v_o=0`, `resp_o=0`, `busy_o=0`, `last=NREQ-1`, `outcnt=0`, sequence=0, state IDLE.
- Request latency: `req_v_i` high in cycle t with the arbiter idle gives `mreq_v_o` high in t+1.
- `mreq_o` is stable while `mreq_v_o & ~mreq_rdy_i`.
- Response latency: `mresp_v_i` in cycle t gives `resp_v_o` in t+1, and it is valid for exactly 1 cycle. There is no backpressure on responses; requesters must sink them.
- `busy_o` is combinational from registered state.

## Configuration
- `RFP_ARB_ICPRIO_EN` defined: requester 0 (I$) has absolute priority whenever eligible. Round-robin applies only among 1..NREQ-1, and `last` is not updated on an I$ grant.
- Not defined: all NREQ requesters share one round-robin.

## Structure
- Add to `rfPhoenixPkg`: `typedef logic [2:0] ReqIdx;`, `parameter ARB_MAXREQ = 8;`, and a tid helper (function `mk_tid(seq, idx)`).
- One sub-module: `rfphoenix_rr_pick`, a parameterised combinational round-robin picker with inputs `elig` and `last`, outputs one-hot `gnt` and `idx`. It is reused by the I$/D$ ways later.

## Test plan
- Single request, `mreq_rdy_i=1`: thread 2 requests at t0 → `mreq_v_o` at t1 with `tid=8'h02`; next grant has `tid[7:3]=1`.
- Round-robin: all of 0..4 request continuously, ready tied high → grant order 0,1,2,3,4,0, one grant every 2 cycles. With `RFP_ARB_ICPRIO_EN` the order is 0,0,0… until I$ reaches MAXOUT=4, then 1,2,3,4.
- Backpressure: `mreq_rdy_i=0` for 5 cycles → `mreq_o` unchanged, `req_rdy_o=0` throughout, accept on cycle 6.
- Outstanding limit: thread 1 issues 4 requests with no responses → a 5th is not granted. One response with `cmt=1`, tid index 1 → grant on the next IDLE cycle.
- Response routing: `mresp_v_i` with `tid=8'h1B` (index 3), `cmt=0` then `cmt=1` → `resp_v_o=5'b01000` for two cycles, `outcnt[3]` decrements once. Tid index 7 → dropped.
- Async reset asserted while in HOLD with 3 outstanding → all outputs 0 immediately. A later stray response does not underflow, and `err_underflow` is set in sim.
